// File: rtl/elevator_scan_ctrl_if.sv
// Request/status bundle between a floor panel (master) and the SCAN elevator controller (slave).
interface elevator_scan_ctrl_if #(
  parameter int unsigned N_FLOORS = 8,
  parameter int unsigned FLOOR_W  = 3
);
  logic [N_FLOORS-1:0] req_in;
  logic [N_FLOORS-1:0] pending;
  logic [FLOOR_W-1:0]  floor_now;
  logic                dir;
  logic                is_move;
  logic                door_open;
  logic [2:0]          ostate;

  modport master (output req_in, input pending, floor_now, dir, is_move, door_open, ostate);
  modport slave  (input req_in, output pending, floor_now, dir, is_move, door_open, ostate);
endinterface

// File: rtl/elevator_scan_ctrl.sv
// Direction-collective (SCAN) elevator controller: latches floor requests, travels one floor
// per travel interval and opens the door at every requested floor it reaches.
module elevator_scan_ctrl #(
  parameter int unsigned N_FLOORS     = 8,
  parameter int unsigned FLOOR_W      = 3,
  parameter int unsigned TRAVEL_TICKS = 10,
  parameter int unsigned DOOR_TICKS   = 100
) (
  input  logic                clk,
  input  logic                irst_n,
  elevator_scan_ctrl_if.slave bus
);

  localparam int unsigned MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int unsigned TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECIDE = 3'd1,
    S_MOVE   = 3'd2,
    S_ARRIVE = 3'd3,
    S_DOOR   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [N_FLOORS-1:0] pending, pending_nxt, clr;
  logic [FLOOR_W-1:0]  floor_now, floor_nxt;
  logic                dir, dir_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic                is_move, door_open;
  logic                here, above, below;

  // Where outstanding requests lie relative to the cab
  always_comb begin
    here  = pending[floor_now];
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) > floor_now) above = 1'b1;
        if (FLOOR_W'(i) < floor_now) below = 1'b1;
      end
    end
  end

  // Next-state, timer and request-clear logic
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    floor_nxt = floor_now;
    timer_nxt = '0;
    clr       = '0;
    unique case (state)
      S_IDLE: if (|pending) state_nxt = S_DECIDE;
      S_DECIDE: begin
        if (here) begin
          state_nxt = S_DOOR;
        end else if (dir ? above : below) begin
          state_nxt = S_MOVE;
        end else if (dir ? below : above) begin
          // reversal is resolved here so it costs no extra cycle
          dir_nxt   = ~dir;
          state_nxt = S_MOVE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_MOVE: begin
        if (timer == TIMER_W'(TRAVEL_TICKS - 1)) begin
          floor_nxt = dir ? (floor_now + FLOOR_W'(1)) : (floor_now - FLOOR_W'(1));
          state_nxt = S_ARRIVE;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      S_ARRIVE: state_nxt = here ? S_DOOR : S_DECIDE;
      S_DOOR: begin
        clr = N_FLOORS'(1) << floor_now;
        if (timer == TIMER_W'(DOOR_TICKS - 1)) begin
          state_nxt = S_DECIDE;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    pending_nxt = (pending | bus.req_in) & ~clr;
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state     <= S_IDLE;
      pending   <= '0;
      floor_now <= '0;
      dir       <= 1'b1;
      timer     <= '0;
      is_move   <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      floor_now <= floor_nxt;
      dir       <= dir_nxt;
      timer     <= timer_nxt;
      is_move   <= (state_nxt == S_MOVE);
      door_open <= (state_nxt == S_DOOR);
    end
  end

  assign bus.pending   = pending;
  assign bus.floor_now = floor_now;
  assign bus.dir       = dir;
  assign bus.is_move   = is_move;
  assign bus.door_open = door_open;
  assign bus.ostate    = state;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: an 8-floor and a 4-floor instance checked every cycle against a
// procedural journey model, plus literal edge-by-edge expectations.
module tb_elevator_scan_ctrl;

  localparam int TT = 4;
  localparam int DT = 6;

  logic clk, clk_en, irst_n;
  int   checks, failures;
  int   edge_n;

  elevator_scan_ctrl_if #(.N_FLOORS(8), .FLOOR_W(3)) bus0 ();
  elevator_scan_ctrl_if #(.N_FLOORS(4), .FLOOR_W(2)) bus1 ();

  elevator_scan_ctrl #(.N_FLOORS(8), .FLOOR_W(3), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) u_dut0 (
    .clk(clk), .irst_n(irst_n), .bus(bus0));
  elevator_scan_ctrl #(.N_FLOORS(4), .FLOOR_W(2), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) u_dut1 (
    .clk(clk), .irst_n(irst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  always @(posedge clk or negedge irst_n) begin
    if (!irst_n) edge_n <= 0;
    else         edge_n <= edge_n + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- journey model: a cab serving requests in sweeps ----------------
  logic [7:0] m_pend [2];
  int         m_floor[2];
  bit         m_dir  [2];
  int         m_st   [2];
  bit         abort_f[2];

  function automatic logic [7:0] reqv(input int k);
    return (k == 0) ? bus0.req_in : {4'b0, bus1.req_in};
  endfunction

  function automatic logic [7:0] mask(input int k);
    return (k == 0) ? 8'hFF : 8'h0F;
  endfunction

  function automatic bit here_f(input int k);
    return m_pend[k][m_floor[k]];
  endfunction

  function automatic bit above_f(input int k);
    for (int i = m_floor[k] + 1; i < 8; i++) if (m_pend[k][i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit below_f(input int k);
    for (int i = 0; i < m_floor[k]; i++) if (m_pend[k][i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock edge; afterwards the cab is in phase st at floor f heading d
  task automatic step(input int k, input int st, input bit d, input int f);
    logic [7:0] one, clr;
    @(posedge clk or negedge irst_n);
    if (!irst_n) begin
      m_pend[k] = '0; m_floor[k] = 0; m_dir[k] = 1'b1; m_st[k] = 0; abort_f[k] = 1'b1;
      return;
    end
    one = 8'd1;
    clr = (m_st[k] == 4) ? (one << m_floor[k]) : 8'd0;
    m_pend[k]  = (m_pend[k] | reqv(k)) & ~clr & mask(k);
    m_st[k]    = st;
    m_dir[k]   = d;
    m_floor[k] = f;
  endtask

  task automatic serve_door(input int k);
    step(k, 4, m_dir[k], m_floor[k]);
    if (abort_f[k]) return;
    repeat (DT - 1) begin
      step(k, 4, m_dir[k], m_floor[k]);
      if (abort_f[k]) return;
    end
    step(k, 1, m_dir[k], m_floor[k]);
  endtask

  task automatic travel(input int k, input bit d);
    int f;
    f = m_floor[k];
    step(k, 2, d, f);
    if (abort_f[k]) return;
    repeat (TT - 1) begin
      step(k, 2, d, f);
      if (abort_f[k]) return;
    end
    step(k, 3, d, d ? f + 1 : f - 1);
  endtask

  task automatic decide(input int k);
    bit ahead, behind;
    ahead  = m_dir[k] ? above_f(k) : below_f(k);
    behind = m_dir[k] ? below_f(k) : above_f(k);
    if (here_f(k))   serve_door(k);
    else if (ahead)  travel(k, m_dir[k]);
    else if (behind) travel(k, !m_dir[k]);
    else             step(k, 0, m_dir[k], m_floor[k]);
  endtask

  task automatic model_run(input int k);
    m_pend[k] = '0; m_floor[k] = 0; m_dir[k] = 1'b1; m_st[k] = 0;
    forever begin
      wait (irst_n === 1'b1);
      abort_f[k] = 1'b0;
      while (!abort_f[k]) begin
        case (m_st[k])
          1:       decide(k);
          3:       if (here_f(k)) serve_door(k); else step(k, 1, m_dir[k], m_floor[k]);
          default: step(k, (m_pend[k] != 0) ? 1 : 0, m_dir[k], m_floor[k]);
        endcase
      end
    end
  endtask

  initial model_run(0);
  initial model_run(1);

  // ---------------- per-cycle compare and door-stop recorder ----------------
  int dq0[$], dq1[$];
  bit pdoor0, pdoor1;

  always @(negedge clk) begin
    chk("pend0",  int'(bus0.pending),   int'(m_pend[0]));
    chk("floor0", int'(bus0.floor_now), m_floor[0]);
    chk("dir0",   int'(bus0.dir),       int'(m_dir[0]));
    chk("move0",  int'(bus0.is_move),   int'(m_st[0] == 2));
    chk("door0",  int'(bus0.door_open), int'(m_st[0] == 4));
    chk("state0", int'(bus0.ostate),    m_st[0]);
    chk("pend1",  int'(bus1.pending),   int'(m_pend[1]));
    chk("floor1", int'(bus1.floor_now), m_floor[1]);
    chk("dir1",   int'(bus1.dir),       int'(m_dir[1]));
    chk("move1",  int'(bus1.is_move),   int'(m_st[1] == 2));
    chk("door1",  int'(bus1.door_open), int'(m_st[1] == 4));
    chk("state1", int'(bus1.ostate),    m_st[1]);
    if (bus0.is_move) chk("move_idle0", int'(bus0.pending != 0), 1);
    if (bus1.is_move) chk("move_idle1", int'(bus1.pending != 0), 1);
    if (bus0.door_open && !pdoor0) dq0.push_back(int'(bus0.floor_now));
    if (bus1.door_open && !pdoor1) dq1.push_back(int'(bus1.floor_now));
    pdoor0 = bus0.door_open;
    pdoor1 = bus1.door_open;
  end

  task automatic at_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  int e0[3];
  int e1[4];

  initial begin
    checks = 0; failures = 0;
    clk_en = 1'b0; irst_n = 1'b1;
    bus0.req_in = '0; bus1.req_in = '0;
    pdoor0 = 1'b0; pdoor1 = 1'b0;
    e0 = '{5, 6, 1};
    e1 = '{0, 1, 2, 3};

    // reset with clock stopped
    #2 irst_n = 1'b0;
    #10;
    chk("rst_state0", int'(bus0.ostate), 0);
    chk("rst_dir0",   int'(bus0.dir), 1);
    chk("rst_floor0", int'(bus0.floor_now), 0);
    chk("rst_pend0",  int'(bus0.pending), 0);
    chk("rst_move0",  int'(bus0.is_move), 0);
    chk("rst_door0",  int'(bus0.door_open), 0);
    chk("rst_state1", int'(bus1.ostate), 0);
    chk("rst_dir1",   int'(bus1.dir), 1);

    clk_en = 1'b1;
    @(negedge clk);
    irst_n = 1'b1;
    bus0.req_in = 8'b0000_1000;
    bus1.req_in = 4'b0001;

    at_edge(1);
    chk("t2_pend3_e1", int'(bus0.pending[3]), 1);
    chk("t4_pend0_e1", int'(bus1.pending[0]), 1);
    bus0.req_in = '0; bus1.req_in = '0;
    at_edge(3);
    chk("t2_move_e3", int'(bus0.ostate), 2);
    chk("t4_door_e3", int'(bus1.ostate), 4);
    at_edge(4);
    bus1.req_in = 4'b0001;
    at_edge(5);
    bus1.req_in = '0;
    chk("t4_absorb_e5", int'(bus1.pending), 0);
    at_edge(7);
    chk("t2_floor_e7", int'(bus0.floor_now), 1);
    at_edge(8);
    chk("t4_door_e8", int'(bus1.door_open), 1);
    at_edge(9);
    chk("t4_decide_e9", int'(bus1.ostate), 1);
    at_edge(10);
    chk("t4_idle_e10", int'(bus1.ostate), 0);
    at_edge(13);
    chk("t2_floor_e13", int'(bus0.floor_now), 2);
    at_edge(19);
    chk("t2_floor_e19", int'(bus0.floor_now), 3);
    at_edge(20);
    chk("t2_door_e20", int'(bus0.ostate), 4);
    chk("t2_pend_e20", int'(bus0.pending), 8);
    at_edge(21);
    chk("t2_pend_e21", int'(bus0.pending), 0);
    at_edge(25);
    chk("t2_door_e25", int'(bus0.door_open), 1);
    at_edge(26);
    chk("t2_decide_e26", int'(bus0.ostate), 1);
    chk("t2_doorc_e26", int'(bus0.door_open), 0);
    at_edge(27);
    chk("t2_idle_e27", int'(bus0.ostate), 0);

    // SCAN ordering on 8 floors, top-floor run on 4 floors
    at_edge(28);
    dq0.delete(); dq1.delete();
    at_edge(29);
    bus0.req_in = 8'b0110_0010;
    bus1.req_in = 4'b1000;
    at_edge(30);
    bus0.req_in = '0; bus1.req_in = '0;
    at_edge(60);
    chk("t5_top_e60", int'(bus1.floor_now), 3);
    bus1.req_in = 4'b0001;
    at_edge(61);
    bus1.req_in = '0;
    at_edge(62);
    chk("t3_flip_e62", int'(bus0.dir), 0);
    at_edge(70);
    chk("t5_down_e70", int'(bus1.dir), 0);
    at_edge(110);
    chk("t3_floor_end", int'(bus0.floor_now), 1);
    chk("t3_nstops", dq0.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_stop_seq", (i < dq0.size()) ? dq0[i] : -1, e0[i]);
    chk("t5_bottom", int'(bus1.floor_now), 0);

    // every floor at once on 4 floors
    dq1.delete();
    bus1.req_in = 4'b1111;
    at_edge(111);
    bus1.req_in = '0;
    at_edge(170);
    chk("t5_nstops", dq1.size(), 4);
    for (int i = 0; i < 4; i++) chk("t5_stop_seq", (i < dq1.size()) ? dq1[i] : -1, e1[i]);
    chk("t5_floor_end", int'(bus1.floor_now), 3);

    // reset in the middle of a move
    bus0.req_in = 8'h80;
    at_edge(171);
    bus0.req_in = '0;
    at_edge(174);
    chk("t6_moving", int'(bus0.is_move), 1);
    #2 irst_n = 1'b0;
    #1;
    chk("t6_state", int'(bus0.ostate), 0);
    chk("t6_floor", int'(bus0.floor_now), 0);
    chk("t6_pend",  int'(bus0.pending), 0);
    chk("t6_floor1", int'(bus1.floor_now), 0);
    repeat (3) @(negedge clk);
    irst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_stay_idle", int'(bus0.ostate), 0);
    chk("t6_no_pend",   int'(bus0.pending), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
